// File: rtl/mux4_rr_scheduler.sv
// ----------------------------------------------------------------------------
// mux4_rr_scheduler
//   Round-robin scheduler for a 4:1 enable-high mux. Arbitrates four request
//   lines, drives the mux select/enable and registers the mux output as a
//   one-bit data stream with a valid flag. The mux itself stays combinational
//   outside this block; its output comes back in on y_in.
//
// Parameters
//   HOLD_CYCLES  max consecutive cycles per grant (1..255)
//   GAP_EN       1: one idle cycle (en=0) between grants, 0: back-to-back
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [3:0] request per mux input
//   sel      out  [1:0] registered mux select
//   en       out  registered mux enable, high while a grant is active
//   gnt      out  [3:0] one-hot grant, (en ? 1<<sel : 0)
//   y_in     in   mux output Y
//   y_out    out  registered sample of y_in
//   y_valid  out  high the cycle after each en-high cycle
//   busy     out  high while in GRANT or GAP
// ----------------------------------------------------------------------------
module mux4_rr_scheduler #(
    parameter int HOLD_CYCLES = 4,
    parameter bit GAP_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       en,
    output logic [3:0] gnt,
    input  logic       y_in,
    output logic       y_out,
    output logic       y_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] LP_RELOAD = 8'(HOLD_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_last;
    logic [1:0] r_sel;
    logic       r_en;
    logic [3:0] r_gnt;
    logic       r_y_out;
    logic       r_y_valid;
    logic       r_busy;

    logic [2:0] w_arb;      // {found, index} scanning after r_last
    logic [2:0] w_rearb;    // {found, index} scanning after the index just served
    logic       w_end;

    // Round-robin pick: scan last+1, last+2, last+3, last (mod 4). The loop
    // runs from the lowest priority up so the highest-priority hit is written last.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign w_arb   = rr_pick(req, r_last);
    // Back-to-back mode re-arbitrates on the same edge that ends a grant, so
    // the just-served index must already count as lowest priority.
    assign w_rearb = rr_pick(req, r_sel);
    assign w_end   = (r_cnt == 8'd0) || !req[r_sel];

    // NOTE: every register below is updated with non-blocking assignments so
    // all of them see the pre-edge values of each other within one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_last    <= 2'd3;      // makes req[0] the first winner
            r_sel     <= 2'd0;
            r_en      <= 1'b0;
            r_gnt     <= 4'b0000;
            r_y_out   <= 1'b0;
            r_y_valid <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_y_valid <= r_en;
            if (r_en) r_y_out <= y_in;

            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_arb[2]) begin
                        r_sel   <= w_arb[1:0];
                        r_en    <= 1'b1;
                        r_gnt   <= 4'b0001 << w_arb[1:0];
                        r_cnt   <= LP_RELOAD;
                        r_state <= ST_GRANT;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_GRANT: begin
                    if (w_end) begin
                        r_last <= r_sel;
                        if (GAP_EN) begin
                            r_en    <= 1'b0;
                            r_gnt   <= 4'b0000;
                            r_state <= ST_GAP;
                        end else if (w_rearb[2]) begin
                            r_sel <= w_rearb[1:0];
                            r_gnt <= 4'b0001 << w_rearb[1:0];
                            r_cnt <= LP_RELOAD;
                        end else begin
                            r_en    <= 1'b0;
                            r_gnt   <= 4'b0000;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_en    <= 1'b0;
                    r_gnt   <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sel     = r_sel;
    assign en      = r_en;
    assign gnt     = r_gnt;
    assign y_out   = r_y_out;
    assign y_valid = r_y_valid;
    assign busy    = r_busy;

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_mux4_rr_scheduler
//   Three scheduler instances share clock, reset and requests:
//     0: defaults (HOLD=4, GAP_EN=1)
//     1: HOLD=1, GAP_EN=0
//     2: HOLD=2, GAP_EN=0
//   Each instance has its own 4:1 mux model built from data_i, feeding y_in.
//   Per-edge expectations live in a queue of vector records.
// ----------------------------------------------------------------------------
module tb_mux4_rr_scheduler;

    typedef struct {
        int         tid;
        int         dut;
        logic [3:0] req;
        logic [3:0] data;
        logic [1:0] sel;
        logic       en;
        logic [3:0] gnt;
        logic       busy;
        logic       yv;
        logic       yout;
        bit         chk_yout;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data_i;

    logic [1:0] o_sel  [3];
    logic       o_en   [3];
    logic [3:0] o_gnt  [3];
    logic       o_busy [3];
    logic       o_yv   [3];
    logic       o_yout [3];
    logic       w_yin  [3];

    int n_pass  = 0;
    int n_total = 0;
    vec_t vq[$];

    assign w_yin[0] = o_en[0] ? data_i[o_sel[0]] : 1'b0;
    assign w_yin[1] = o_en[1] ? data_i[o_sel[1]] : 1'b0;
    assign w_yin[2] = o_en[2] ? data_i[o_sel[2]] : 1'b0;

    mux4_rr_scheduler #(.HOLD_CYCLES(4), .GAP_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .sel(o_sel[0]), .en(o_en[0]),
        .gnt(o_gnt[0]), .y_in(w_yin[0]), .y_out(o_yout[0]), .y_valid(o_yv[0]),
        .busy(o_busy[0]));

    mux4_rr_scheduler #(.HOLD_CYCLES(1), .GAP_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .sel(o_sel[1]), .en(o_en[1]),
        .gnt(o_gnt[1]), .y_in(w_yin[1]), .y_out(o_yout[1]), .y_valid(o_yv[1]),
        .busy(o_busy[1]));

    mux4_rr_scheduler #(.HOLD_CYCLES(2), .GAP_EN(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req), .sel(o_sel[2]), .en(o_en[2]),
        .gnt(o_gnt[2]), .y_in(w_yin[2]), .y_out(o_yout[2]), .y_valid(o_yv[2]),
        .busy(o_busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input int tid, input int dut, input logic [3:0] rq,
                                input logic [3:0] data, input logic [1:0] sel,
                                input logic en, input logic busy, input logic yv,
                                input logic yout, input bit chk_yout);
        vec_t v;
        v.tid = tid; v.dut = dut; v.req = rq; v.data = data; v.sel = sel;
        v.en = en; v.gnt = en ? (4'b0001 << sel) : 4'b0000;
        v.busy = busy; v.yv = yv; v.yout = yout; v.chk_yout = chk_yout;
        return v;
    endfunction

    // Precondition: called at a negedge. Each vector drives inputs, waits for
    // the edge, then compares just after it; returns at a negedge.
    task automatic run_vecs();
        vec_t v;
        int   d;
        string tag;
        for (int k = 0; k < vq.size(); k++) begin
            v = vq[k];
            d = v.dut;
            req    = v.req;
            data_i = v.data;
            @(posedge clk);
            #1;
            tag = $sformatf("T%0d[%0d]", v.tid, k);
            check({tag, ".sel"},  {6'b0, o_sel[d]},  {6'b0, v.sel});
            check({tag, ".en"},   {7'b0, o_en[d]},   {7'b0, v.en});
            check({tag, ".gnt"},  {4'b0, o_gnt[d]},  {4'b0, v.gnt});
            check({tag, ".busy"}, {7'b0, o_busy[d]}, {7'b0, v.busy});
            check({tag, ".yv"},   {7'b0, o_yv[d]},   {7'b0, v.yv});
            if (v.chk_yout) check({tag, ".yout"}, {7'b0, o_yout[d]}, {7'b0, v.yout});
            @(negedge clk);
        end
        vq.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag, input int d);
        check({tag, ".sel"},  {6'b0, o_sel[d]},  8'h00);
        check({tag, ".en"},   {7'b0, o_en[d]},   8'h00);
        check({tag, ".gnt"},  {4'b0, o_gnt[d]},  8'h00);
        check({tag, ".busy"}, {7'b0, o_busy[d]}, 8'h00);
        check({tag, ".yv"},   {7'b0, o_yv[d]},   8'h00);
        check({tag, ".yout"}, {7'b0, o_yout[d]}, 8'h00);
    endtask

    initial begin
        int         phase;
        int         idx;
        logic [3:0] dat;
        logic [1:0] s;
        logic [1:0] prev_s;

        // T1: reset with all requests high, outputs must be zero.
        rst_n  = 1'b0;
        req    = 4'hF;
        data_i = 4'b1010;
        @(negedge clk);
        check_all_zero("T1.rst_a", 0);
        check_all_zero("T1.rst_b", 1);
        check_all_zero("T1.rst_c", 2);
        rst_n = 1'b1;

        // T1/T2: first edge grants index 0; then 4-cycle grants with 1-cycle
        // gaps rotating 0,1,2,3,0 (period 5).
        dat = 4'b1010;
        for (int k = 0; k < 21; k++) begin
            phase = k % 5;
            idx   = (k / 5) % 4;
            s     = 2'(idx);
            if (phase == 0)
                vq.push_back(mk(2, 0, 4'hF, dat, s, 1'b1, 1'b1, 1'b0,
                                (k == 0) ? 1'b0 : dat[2'(idx - 1)], 1'b1));
            else if (phase < 4)
                vq.push_back(mk(2, 0, 4'hF, dat, s, 1'b1, 1'b1, 1'b1, dat[s], 1'b1));
            else
                vq.push_back(mk(2, 0, 4'hF, dat, s, 1'b0, 1'b1, 1'b1, dat[s], 1'b1));
        end
        run_vecs();

        // T3: single requester drops after two cycles -> GAP then IDLE.
        do_reset();
        dat = 4'b0100;
        vq.push_back(mk(3, 0, 4'b0100, dat, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(3, 0, 4'b0100, dat, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        vq.push_back(mk(3, 0, 4'b0000, dat, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
        vq.push_back(mk(3, 0, 4'b0000, dat, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        vq.push_back(mk(3, 0, 4'b0000, dat, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        run_vecs();

        // T4: HOLD=1, no gap: one-cycle grants, continuous valid, alternating data.
        do_reset();
        dat = 4'b1010;
        for (int k = 0; k < 9; k++) begin
            s = 2'(k % 4);
            vq.push_back(mk(4, 1, 4'hF, dat, s, 1'b1, 1'b1, (k > 0),
                            (k == 0) ? 1'b0 : dat[2'((k - 1) % 4)], 1'b1));
        end
        run_vecs();

        // T6: HOLD=2, no gap, req=1001: sel 0,0,3,3,0,0,3 with en never dropping.
        do_reset();
        dat    = 4'b1000;
        prev_s = 2'd0;
        for (int k = 0; k < 7; k++) begin
            s = ((k / 2) % 2 == 0) ? 2'd0 : 2'd3;
            vq.push_back(mk(6, 2, 4'b1001, dat, s, 1'b1, 1'b1, (k > 0),
                            (k == 0) ? 1'b0 : dat[prev_s], 1'b1));
            prev_s = s;
        end
        // Requester 3 drops while granted: grant ends, 0 takes over without a gap.
        vq.push_back(mk(6, 2, 4'b0001, dat, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        // Nobody requesting: back to IDLE, last sample of index 0 delivered.
        vq.push_back(mk(6, 2, 4'b0000, dat, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        run_vecs();

        // T5: reset mid-grant on index 2 clears outputs before the next edge.
        do_reset();
        dat = 4'b0100;
        vq.push_back(mk(5, 0, 4'b0100, dat, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(5, 0, 4'b0100, dat, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        run_vecs();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("T5.mid", 0);
        req = 4'b0101;
        @(negedge clk);
        rst_n = 1'b1;
        vq.push_back(mk(5, 0, 4'b0101, dat, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        run_vecs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
